// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: frames index/argument with CRC7, serialises it MSB-first,
// then optionally captures a 48/136-bit response and checks its CRC7 and end bit.
module sd_cmd_phy #(
  parameter int TIMEOUT   = 64,
  parameter int SHORT_LEN = 48,
  parameter int LONG_LEN  = 136
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_send,
  input  logic [5:0]          cmd_index,
  input  logic [31:0]         cmd_arg,
  input  logic [1:0]          resp_type,
  input  logic                resp_ack,
  input  logic                cmd_in,
  output logic                cmd_out,
  output logic                cmd_oe,
  output logic                serial_ready,
  output logic                ack_out,
  output logic                strobe_out,
  output logic [LONG_LEN-1:0] response,
  output logic                crc_err,
  output logic                timeout_err
);

  localparam int MAXC = (TIMEOUT > LONG_LEN) ? TIMEOUT : LONG_LEN;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_FRAME  = CW'(40);
  localparam logic [CW-1:0] C_CRC    = CW'(47);
  localparam logic [CW-1:0] C_TOUT   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_LAST_S = CW'(SHORT_LEN - 1);
  localparam logic [CW-1:0] C_LAST_L = CW'(LONG_LEN - 1);
  localparam logic [CW-1:0] C_HI_S   = CW'(SHORT_LEN - 8);
  localparam logic [CW-1:0] C_LO_L   = CW'(LONG_LEN - 128);
  localparam logic [CW-1:0] C_HI_L   = CW'(LONG_LEN - 8);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT, RECV, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [39:0]         frame_q, frame_d;
  logic [6:0]          crc_q, crc_d;
  logic [1:0]          rtype_q, rtype_d;
  logic [LONG_LEN-1:0] rx_q, rx_d;
  logic                crc_err_q, crc_err_d;
  logic                tout_q, tout_d;
  logic                ack_q, ack_d;

  logic                rt_long;
  logic [CW-1:0]       last_idx, crc_lo, crc_hi;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Long responses exclude their 8 leading header bits from the CRC.
  assign rt_long  = (rtype_q == 2'b10);
  assign last_idx = rt_long ? C_LAST_L : C_LAST_S;
  assign crc_lo   = rt_long ? C_LO_L : '0;
  assign crc_hi   = rt_long ? C_HI_L : C_HI_S;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    crc_d        = crc_q;
    rtype_d      = rtype_q;
    rx_d         = rx_q;
    crc_err_d    = crc_err_q;
    tout_d       = tout_q;
    ack_d        = 1'b0;
    cmd_out      = 1'b1;
    cmd_oe       = 1'b0;
    serial_ready = 1'b0;
    strobe_out   = 1'b0;
    case (state_q)
      IDLE: begin
        serial_ready = 1'b1;
        if (load_send) begin
          frame_d   = {2'b01, cmd_index, cmd_arg};
          rtype_d   = resp_type;
          crc_d     = '0;
          rx_d      = '0;
          crc_err_d = 1'b0;
          tout_d    = 1'b0;
          ack_d     = 1'b1;
          cnt_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        cmd_oe = 1'b1;
        cnt_d  = cnt_q + C_ONE;
        if (cnt_q < C_FRAME) begin
          cmd_out = frame_q[39];
          crc_d   = crc7_step(crc_q, frame_q[39]);
          frame_d = {frame_q[38:0], 1'b0};
        end else if (cnt_q < C_CRC) begin
          cmd_out = crc_q[6];
          crc_d   = {crc_q[5:0], 1'b0};
        end else begin
          cnt_d   = '0;
          state_d = (rtype_q == 2'b00) ? DONE : TURN;
        end
      end
      TURN: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!cmd_in) begin
          rx_d    = {rx_q[LONG_LEN-2:0], 1'b0};
          crc_d   = '0;
          cnt_d   = C_ONE;
          state_d = RECV;
        end else if (cnt_q == C_TOUT) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      RECV: begin
        rx_d  = {rx_q[LONG_LEN-2:0], cmd_in};
        cnt_d = cnt_q + C_ONE;
        if (cnt_q >= crc_lo && cnt_q < crc_hi)
          crc_d = crc7_step(crc_q, cmd_in);
        if (cnt_q == last_idx) begin
          // rx_q[6:0] already holds the received CRC; cmd_in is the end bit.
          crc_err_d = ((rtype_q != 2'b11) && (crc_q != rx_q[6:0])) || !cmd_in;
          state_d   = DONE;
        end
      end
      DONE: begin
        strobe_out = 1'b1;
        if (resp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      crc_q     <= '0;
      rtype_q   <= '0;
      rx_q      <= '0;
      crc_err_q <= 1'b0;
      tout_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      crc_q     <= crc_d;
      rtype_q   <= rtype_d;
      rx_q      <= rx_d;
      crc_err_q <= crc_err_d;
      tout_q    <= tout_d;
      ack_q     <= ack_d;
    end
  end

  assign ack_out     = ack_q;
  assign response    = rx_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Randomised self-checking bench for sd_cmd_phy; the reference model builds
// frames and responses from CRC7 polynomial division.
module tb_sd_cmd_phy;
  localparam int TIMEOUT = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load_send = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         resp_ack = 1'b0;
  logic         cmd_in = 1'b1;
  logic         cmd_out, cmd_oe, serial_ready, ack_out, strobe_out, crc_err, timeout_err;
  logic [135:0] response;

  int checks = 0;
  int errors = 0;

  sd_cmd_phy #(.TIMEOUT(TIMEOUT), .SHORT_LEN(48), .LONG_LEN(136)) dut (
    .clock(clock), .reset(reset), .load_send(load_send), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_type(resp_type), .resp_ack(resp_ack), .cmd_in(cmd_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .serial_ready(serial_ready), .ack_out(ack_out),
    .strobe_out(strobe_out), .response(response), .crc_err(crc_err),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Remainder of msg(x)*x^7 divided by x^7+x^3+1, msg being the low n bits.
  function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r = r ^ (135'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_div({88'b0, body}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] short_resp(input logic [5:0] idx, input logic [31:0] pl);
    logic [39:0] body;
    body = {2'b00, idx, pl};
    return {88'b0, body, crc7_div({88'b0, body}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] long_resp();
    logic [119:0] body;
    for (int i = 0; i < 4; i++) body[i*30 +: 30] = 30'($urandom);
    return {8'h3F, body, crc7_div({8'b0, body}, 120), 1'b1};
  endfunction

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input int poke, output logic [47:0] got, output int oe_n,
                          output int ack_n, output logic ack_first);
    got = '0; oe_n = 0; ack_n = 0;
    cmd_index = idx; cmd_arg = arg; resp_type = rt; load_send = 1'b1;
    step();
    load_send = 1'b0;
    ack_first = ack_out;
    for (int i = 0; i < 60; i++) begin
      if (cmd_oe) begin got = {got[46:0], cmd_out}; oe_n++; end
      if (ack_out) ack_n++;
      if (i == poke) begin load_send = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; end
      else load_send = 1'b0;
      if (!cmd_oe && oe_n > 0) break;
      step();
    end
    load_send = 1'b0;
  endtask

  // Entered in the turnaround cycle; d idle WAIT cycles precede the start bit.
  task automatic drive_resp(input logic [135:0] bits, input int len, input int d);
    cmd_in = 1'b1;
    step();
    repeat (d) step();
    for (int i = len - 1; i >= 0; i--) begin cmd_in = bits[i]; step(); end
    cmd_in = 1'b1;
  endtask

  task automatic release_resp();
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
    checks++;
    if (serial_ready !== 1'b1 || strobe_out !== 1'b0) begin
      errors++;
      $display("FAIL release: serial_ready=%b strobe=%b, want 1/0", serial_ready, strobe_out);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({cmd_out, cmd_oe, serial_ready, ack_out, strobe_out, crc_err, timeout_err} !== 7'b1010000
        || response !== '0) begin
      errors++;
      $display("FAIL %s: out/oe/rdy/ack/stb/crc/to=%b%b%b%b%b%b%b resp=%h, want 1010000 resp=0",
               tag, cmd_out, cmd_oe, serial_ready, ack_out, strobe_out, crc_err, timeout_err,
               response);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_vals("reset_asserted");
    reset = 1'b1;
    step(); step();
    check_reset_vals("reset_released");
  endtask

  task automatic test_cmd0();
    logic [47:0] got; int oe_n, ack_n; logic ack_first;
    send_cmd(6'd0, 32'h0, 2'b00, -1, got, oe_n, ack_n, ack_first);
    checks++;
    if (got !== 48'h400000000095 || got !== model_frame(6'd0, 32'h0)) begin
      errors++; $display("FAIL cmd0_frame: got %h want 400000000095", got);
    end
    checks++;
    if (oe_n != 48 || ack_n != 1 || ack_first !== 1'b1) begin
      errors++; $display("FAIL cmd0_oe_ack: oe=%0d acks=%0d first=%b want 48/1/1", oe_n, ack_n, ack_first);
    end
    checks++;
    if (strobe_out !== 1'b1 || crc_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL cmd0_strobe: stb=%b crc=%b to=%b want 1/0/0", strobe_out, crc_err, timeout_err);
    end
    step(); step();
    checks++;
    if (strobe_out !== 1'b1 || serial_ready !== 1'b0) begin
      errors++; $display("FAIL cmd0_hold: stb=%b rdy=%b want 1/0", strobe_out, serial_ready);
    end
    release_resp();
  endtask

  task automatic test_cmd8();
    logic [47:0] got; int oe_n, ack_n; logic ack_first; logic [135:0] r;
    send_cmd(6'd8, 32'h1AA, 2'b01, -1, got, oe_n, ack_n, ack_first);
    checks++;
    if (got !== 48'h48000001AA87) begin
      errors++; $display("FAIL cmd8_frame: got %h want 48000001aa87", got);
    end
    r = short_resp(6'd8, 32'h1AA);
    drive_resp(r, 48, 5);
    checks++;
    if (response !== r || crc_err !== 1'b0 || timeout_err !== 1'b0 || strobe_out !== 1'b1) begin
      errors++; $display("FAIL cmd8_resp: got %h crc=%b to=%b stb=%b want %h/0/0/1",
                         response, crc_err, timeout_err, strobe_out, r);
    end
    release_resp();
  endtask

  // Mode 0: flip a CRC bit, 1: end bit 0, 2: valid at the last WAIT slot, 3/4: rt=11 bad CRC / bad end
  task automatic test_crc_errors();
    logic [47:0] got; int oe_n, ack_n; logic ack_first; logic [135:0] r;
    logic [5:0] idx; logic [31:0] arg; logic [1:0] rt; logic want; int d;
    for (int m = 0; m < 5; m++) begin
      idx = 6'($urandom); arg = $urandom;
      rt = (m >= 3) ? 2'b11 : 2'b01;
      send_cmd(idx, arg, rt, -1, got, oe_n, ack_n, ack_first);
      checks++;
      if (got !== model_frame(idx, arg)) begin
        errors++; $display("FAIL crc_frame%0d: got %h want %h", m, got, model_frame(idx, arg));
      end
      r = short_resp(idx, $urandom);
      d = (m == 2) ? TIMEOUT - 1 : int'($urandom_range(0, 10));
      if (m == 0 || m == 3) r[$urandom_range(1, 7)] ^= 1'b1;
      if (m == 1 || m == 4) r[0] = 1'b0;
      want = (m == 0 || m == 1 || m == 4);
      drive_resp(r, 48, d);
      checks++;
      if (crc_err !== want || response !== r || timeout_err !== 1'b0) begin
        errors++; $display("FAIL crc_mode%0d: crc=%b resp=%h to=%b want %b/%h/0",
                           m, crc_err, response, timeout_err, want, r);
      end
      release_resp();
    end
  endtask

  task automatic test_long();
    logic [47:0] got; int oe_n, ack_n; logic ack_first; logic [135:0] r; logic want;
    for (int k = 0; k < 4; k++) begin
      send_cmd(6'd2, (k == 0) ? 32'h0 : $urandom, 2'b10, -1, got, oe_n, ack_n, ack_first);
      r = long_resp();
      want = (k == 3);
      if (want) r[$urandom_range(1, 7)] ^= 1'b1;
      drive_resp(r, 136, $urandom_range(0, 12));
      checks++;
      if (response !== r || crc_err !== want || strobe_out !== 1'b1) begin
        errors++; $display("FAIL long%0d: got %h crc=%b stb=%b want %h/%b/1",
                           k, response, crc_err, strobe_out, r, want);
      end
      release_resp();
    end
  endtask

  task automatic test_timeout();
    logic [47:0] got; int oe_n, ack_n; logic ack_first; int n;
    send_cmd(6'd17, $urandom, 2'b01, -1, got, oe_n, ack_n, ack_first);
    cmd_in = 1'b1;
    step();
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != TIMEOUT) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT);
    end
    checks++;
    if (strobe_out !== 1'b1 || response !== '0 || crc_err !== 1'b0) begin
      errors++; $display("FAIL timeout_state: stb=%b resp=%h crc=%b want 1/0/0", strobe_out, response, crc_err);
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    logic [47:0] got; int oe_n, ack_n; logic ack_first; logic [5:0] idx; logic [31:0] arg;
    for (int k = 0; k < 4; k++) begin
      idx = 6'($urandom); arg = $urandom;
      send_cmd(idx, arg, 2'b00, (k == 0) ? 12 : -1, got, oe_n, ack_n, ack_first);
      checks++;
      if (got !== model_frame(idx, arg) || ack_n != 1 || oe_n != 48) begin
        errors++; $display("FAIL b2b%0d: got %h acks=%0d oe=%0d want %h/1/48",
                           k, got, ack_n, oe_n, model_frame(idx, arg));
      end
      release_resp();
    end
  endtask

  task automatic test_abort();
    logic [47:0] got; int oe_n, ack_n; logic ack_first;
    cmd_index = 6'd9; cmd_arg = $urandom; resp_type = 2'b01; load_send = 1'b1;
    step();
    load_send = 1'b0;
    repeat (20) step();
    #2 reset = 1'b0;
    #1;
    check_reset_vals("abort");
    step(); step();
    #2 reset = 1'b1;
    step();
    check_reset_vals("abort_released");
    send_cmd(6'd55, 32'h0, 2'b00, -1, got, oe_n, ack_n, ack_first);
    checks++;
    if (got !== 48'h770000000065 || oe_n != 48) begin
      errors++; $display("FAIL cmd55: got %h oe=%0d want 770000000065/48", got, oe_n);
    end
    release_resp();
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_errors();
    test_long();
    test_timeout();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
